// File: rtl/queue_sensor_conditioner.sv
// -----------------------------------------------------------------------------
// queue_sensor_conditioner
//   Front end of the bank-queue counter. It turns the raw entry and exit sensor
//   inputs into clean single-cycle count pulses on the system clock. Each
//   sensor is synchronized, debounced and edge-detected. Simultaneous presses
//   are arbitrated, and any count that would overflow or underflow the queue is
//   blocked using the full/empty flags fed back from the flags stage.
//
//   Ports
//     clk         in   system clock, all state changes on posedge
//     reset       in   asynchronous active-low reset
//     up_raw      in   raw entry sensor (async, may bounce)
//     down_raw    in   raw exit sensor (async, may bounce)
//     full_flag   in   queue full; sampled only in the qualify cycle
//     empty_flag  in   queue empty; sampled only in the qualify cycle
//     up_pulse    out  one-cycle increment request
//     down_pulse  out  one-cycle decrement request
//     reject      out  one-cycle strobe: a qualified press was blocked
//     collide     out  one-cycle strobe: up and down qualified together
//     up_level    out  debounced entry sensor level
//     down_level  out  debounced exit sensor level
// -----------------------------------------------------------------------------

// Per-sensor channel: 2-flop synchronizer, then a debounce FSM that fires
// qualify_o for one cycle (combinationally, on the PRESS_DB -> PRESSED step).
module qsc_sensor_chan #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic qualify_o,
    output logic level_o
);
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] PRESS_DB = 2'd1;
    localparam logic [1:0] PRESSED  = 2'd2;
    localparam logic [1:0] REL_DB   = 2'd3;

    // The counter reaches DEBOUNCE_CYCLES on the edge where it was at
    // DEBOUNCE_CYCLES-1 and sees one more stable sample; that edge completes
    // the debounce, so the count never has to hold the terminal value itself.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             s1_q, s2_q;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        qualify_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (s2_q) begin
                    state_d = PRESS_DB;
                    cnt_d   = CNT_ONE;
                end
            end
            PRESS_DB: begin
                if (!s2_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = PRESSED;
                    cnt_d     = '0;
                    qualify_o = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            PRESSED: begin
                if (!s2_q) begin
                    state_d = REL_DB;
                    cnt_d   = CNT_ONE;
                end
            end
            REL_DB: begin
                if (s2_q) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            state_q <= IDLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            s1_q    <= raw_i;
            s2_q    <= s1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            // PRESSED and REL_DB are the two states with bit 1 set
            level_q <= state_d[1];
        end
    end

    assign level_o = level_q;
endmodule

module queue_sensor_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic up_raw,
    input  logic down_raw,
    input  logic full_flag,
    input  logic empty_flag,
    output logic up_pulse,
    output logic down_pulse,
    output logic reject,
    output logic collide,
    output logic up_level,
    output logic down_level
);
    // lane 0 = up (entry), lane 1 = down (exit)
    logic [1:0] raw, qual, lvl;
    logic       qu, qd;
    logic       up_q, up_d, dn_q, dn_d, rej_q, rej_d, col_q, col_d;

    assign raw = {down_raw, up_raw};

    qsc_sensor_chan #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_chan [1:0] (
        .clk      (clk),
        .rst_n    (reset),
        .raw_i    (raw),
        .qualify_o(qual),
        .level_o  (lvl)
    );

    assign qu = qual[0];
    assign qd = qual[1];

    // Flags matter only in the qualify cycle. A simultaneous up/down pair
    // cancels out, so neither pulse is sent and only collide is flagged.
    always_comb begin
        col_d = qu & qd;
        up_d  = qu & ~qd & ~full_flag;
        dn_d  = qd & ~qu & ~empty_flag;
        rej_d = (qu & ~qd & full_flag) | (qd & ~qu & empty_flag);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            up_q  <= 1'b0;
            dn_q  <= 1'b0;
            rej_q <= 1'b0;
            col_q <= 1'b0;
        end else begin
            up_q  <= up_d;
            dn_q  <= dn_d;
            rej_q <= rej_d;
            col_q <= col_d;
        end
    end

    assign up_pulse   = up_q;
    assign down_pulse = dn_q;
    assign reject     = rej_q;
    assign collide    = col_q;
    assign up_level   = lvl[0];
    assign down_level = lvl[1];
endmodule

// File: tb/tb_queue_sensor_conditioner.sv
// Bench for queue_sensor_conditioner: directed scenarios plus a random phase,
// all checked every cycle against a reference model that tracks, per sensor,
// how many consecutive synchronized samples disagree with the debounced level.
module tb_queue_sensor_conditioner;
    localparam int DB = 16;

    logic clk = 1'b0;
    logic reset, up_raw, down_raw, full_flag, empty_flag;
    logic up_pulse, down_pulse, reject, collide, up_level, down_level;

    queue_sensor_conditioner #(.DEBOUNCE_CYCLES(DB), .CNT_W(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .up_raw    (up_raw),
        .down_raw  (down_raw),
        .full_flag (full_flag),
        .empty_flag(empty_flag),
        .up_pulse  (up_pulse),
        .down_pulse(down_pulse),
        .reject    (reject),
        .collide   (collide),
        .up_level  (up_level),
        .down_level(down_level)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0, cyc = 0;
    // reference model state, index 0 = up, 1 = down
    int m_run [2];
    bit m_s1 [2], m_s2 [2], m_lvl [2], m_q [2];
    bit e_up, e_dn, e_rej, e_col;
    // observed event tallies
    int n_up, n_dn, n_rej, n_col, n_uplvl, last_up, last_dn;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_run[i] = 0; m_s1[i] = 0; m_s2[i] = 0; m_lvl[i] = 0; m_q[i] = 0;
        end
        e_up = 0; e_dn = 0; e_rej = 0; e_col = 0;
    endtask

    // Debounced level flips once DB consecutive synchronized samples differ
    // from it; a 0->1 flip is a qualified press.
    task automatic model_edge();
        bit r [2];
        r[0] = up_raw; r[1] = down_raw;
        for (int i = 0; i < 2; i++) begin
            m_q[i] = 0;
            if (m_s2[i] != m_lvl[i]) begin
                m_run[i]++;
                if (m_run[i] == DB) begin
                    m_lvl[i] = ~m_lvl[i];
                    m_run[i] = 0;
                    m_q[i]   = m_lvl[i];
                end
            end else begin
                m_run[i] = 0;
            end
            m_s2[i] = m_s1[i];
            m_s1[i] = r[i];
        end
        e_col = m_q[0] && m_q[1];
        e_up  = m_q[0] && !m_q[1] && !full_flag;
        e_dn  = m_q[1] && !m_q[0] && !empty_flag;
        e_rej = (m_q[0] && !m_q[1] && full_flag) || (m_q[1] && !m_q[0] && empty_flag);
    endtask

    task automatic chk_outputs();
        chk("up_pulse",   32'(up_pulse),   32'(e_up));
        chk("down_pulse", 32'(down_pulse), 32'(e_dn));
        chk("reject",     32'(reject),     32'(e_rej));
        chk("collide",    32'(collide),    32'(e_col));
        chk("up_level",   32'(up_level),   32'(m_lvl[0]));
        chk("down_level", 32'(down_level), 32'(m_lvl[1]));
        chk("pulse_excl", 32'(up_pulse & down_pulse), 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        if (!reset) model_reset(); else model_edge();
        #1;
        chk_outputs();
        if (up_pulse)   begin n_up++; last_up = cyc; end
        if (down_pulse) begin n_dn++; last_dn = cyc; end
        if (reject)     n_rej++;
        if (collide)    n_col++;
        if (up_level)   n_uplvl++;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic clr();
        n_up = 0; n_dn = 0; n_rej = 0; n_col = 0; n_uplvl = 0; last_up = 0; last_dn = 0;
    endtask

    task automatic do_reset(input int hold);
        reset = 1'b0;
        model_reset();
        #1;
        chk_outputs();
        run(hold);
        reset = 1'b1;
    endtask

    int t0;

    initial begin
        reset = 1'b0; up_raw = 0; down_raw = 0; full_flag = 0; empty_flag = 0;
        model_reset();
        run(3);
        reset = 1'b1;
        run(5);

        // 1 clean press: pulse 2+DB edges after the raw change is first sampled
        clr(); t0 = cyc; up_raw = 1; run(40); up_raw = 0; run(40);
        chk("t1_count", n_up, 1);
        chk("t1_latency", last_up - t0, 2 + DB);

        // 2 bounce shorter than the debounce window
        clr();
        for (int i = 0; i < 10; i++) begin up_raw = ~up_raw; run(3); end
        up_raw = 0; run(40);
        chk("t2_count", n_up, 0);
        chk("t2_level", n_uplvl, 0);

        // 3 blocked by full / empty
        clr(); full_flag = 1; up_raw = 1; run(40); up_raw = 0; run(40); full_flag = 0;
        chk("t3_full_rej", n_rej, 1);
        chk("t3_full_up", n_up, 0);
        clr(); empty_flag = 1; down_raw = 1; run(40); down_raw = 0; run(40); empty_flag = 0;
        chk("t3_empty_rej", n_rej, 1);
        chk("t3_empty_dn", n_dn, 0);

        // 4 collision
        clr(); up_raw = 1; down_raw = 1; run(40); up_raw = 0; down_raw = 0; run(40);
        chk("t4_collide", n_col, 1);
        chk("t4_pulses", n_up + n_dn, 0);

        // 5 staggered by one cycle
        clr(); up_raw = 1; tick(); down_raw = 1; run(40); up_raw = 0; down_raw = 0; run(40);
        chk("t5_up", n_up, 1);
        chk("t5_dn", n_dn, 1);
        chk("t5_gap", last_dn - last_up, 1);

        // 6 reset mid-debounce with the sensor still held
        up_raw = 1; run(12);
        do_reset(3);
        clr(); t0 = cyc; run(40);
        chk("t6_count", n_up, 1);
        chk("t6_latency", last_up - t0, 2 + DB);
        up_raw = 0; run(40);

        // random phase: hold lengths straddle the debounce window
        for (int seg = 0; seg < 120; seg++) begin
            up_raw     = 1'($urandom_range(0, 1));
            down_raw   = 1'($urandom_range(0, 1));
            full_flag  = ($urandom_range(0, 3) == 0);
            empty_flag = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 40) == 0) do_reset($urandom_range(1, 4));
            run($urandom_range(1, 40));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
